// File: rtl/chess_render_pkg.sv
// Shared state encoding, piece-code ranges and default palette for the board pixel streamer.
package chess_render_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } renderState_t;

   localparam logic [3:0] WHITE_FIRST = 4'd1;
   localparam logic [3:0] WHITE_LAST  = 4'd6;
   localparam logic [3:0] BLACK_FIRST = 4'd7;
   localparam logic [3:0] BLACK_LAST  = 4'd12;

   localparam logic [15:0] DEF_LIGHT_COLOUR       = 16'hEF7D;
   localparam logic [15:0] DEF_DARK_COLOUR        = 16'h8A22;
   localparam logic [15:0] DEF_HIGHLIGHT_COLOUR   = 16'hFFE0;
   localparam logic [15:0] DEF_WHITE_PIECE_COLOUR = 16'hFFFF;
   localparam logic [15:0] DEF_BLACK_PIECE_COLOUR = 16'h0000;

   function automatic logic isWhitePiece(input logic [3:0] code);
      return (code >= WHITE_FIRST) && (code <= WHITE_LAST);
   endfunction

   function automatic logic isBlackPiece(input logic [3:0] code);
      return (code >= BLACK_FIRST) && (code <= BLACK_LAST);
   endfunction

endpackage

// File: rtl/chess_pixel_colour.sv
// Combinational RGB565 colour of one pixel from its square byte and in-square offset.
// Zero latency; no handshake, the caller registers the result.
module chess_pixel_colour
   import chess_render_pkg::*;
#(
   parameter int SQUARE_PIXELS = 30,
   parameter int BORDER_PIXELS = 2,
   parameter int PIECE_MARGIN  = 6,
   parameter int OFF_W         = $clog2(SQUARE_PIXELS),
   parameter logic [15:0] LIGHT_COLOUR       = DEF_LIGHT_COLOUR,
   parameter logic [15:0] DARK_COLOUR        = DEF_DARK_COLOUR,
   parameter logic [15:0] HIGHLIGHT_COLOUR   = DEF_HIGHLIGHT_COLOUR,
   parameter logic [15:0] WHITE_PIECE_COLOUR = DEF_WHITE_PIECE_COLOUR,
   parameter logic [15:0] BLACK_PIECE_COLOUR = DEF_BLACK_PIECE_COLOUR
)(
   input  logic [7:0]       squareByte,
   input  logic             parityOdd,
   input  logic [OFF_W-1:0] offX,
   input  logic [OFF_W-1:0] offY,
   output logic [15:0]      pixel
);

   localparam logic [OFF_W-1:0] BORDER_LO = OFF_W'(BORDER_PIXELS);
   localparam logic [OFF_W-1:0] BORDER_HI = OFF_W'(SQUARE_PIXELS - 1 - BORDER_PIXELS);
   localparam logic [OFF_W-1:0] PIECE_LO  = OFF_W'(PIECE_MARGIN);
   localparam logic [OFF_W-1:0] PIECE_HI  = OFF_W'(SQUARE_PIXELS - 1 - PIECE_MARGIN);

   logic onBorder;
   logic inPiece;

   assign onBorder = (offX < BORDER_LO) || (offX > BORDER_HI) ||
                     (offY < BORDER_LO) || (offY > BORDER_HI);
   assign inPiece  = (offX >= PIECE_LO) && (offX <= PIECE_HI) &&
                     (offY >= PIECE_LO) && (offY <= PIECE_HI);

   // Highlight beats piece beats background; unused codes fall through to background.
   always_comb begin
      pixel = parityOdd ? DARK_COLOUR : LIGHT_COLOUR;
      if ((squareByte[7:4] != 4'd0) && onBorder)
         pixel = HIGHLIGHT_COLOUR;
      else if (inPiece && isWhitePiece(squareByte[3:0]))
         pixel = WHITE_PIECE_COLOUR;
      else if (inPiece && isBlackPiece(squareByte[3:0]))
         pixel = BLACK_PIECE_COLOUR;
   end

endmodule

// File: rtl/chess_board_pixel_streamer.sv
// Snapshots the 64-square layout on FrameRequest and streams the board as raster RGB565 beats.
// First beat two cycles after the request; a stalled beat holds data and flags, no bubbles while ready.
module chess_board_pixel_streamer
   import chess_render_pkg::*;
#(
   parameter int CHESS_SQUARES = 64,
   parameter int SQUARE_WIDTH  = 8,
   parameter int SQUARE_PIXELS = 30,
   parameter int BORDER_PIXELS = 2,
   parameter int PIECE_MARGIN  = 6,
   parameter logic [15:0] LIGHT_COLOUR       = DEF_LIGHT_COLOUR,
   parameter logic [15:0] DARK_COLOUR        = DEF_DARK_COLOUR,
   parameter logic [15:0] HIGHLIGHT_COLOUR   = DEF_HIGHLIGHT_COLOUR,
   parameter logic [15:0] WHITE_PIECE_COLOUR = DEF_WHITE_PIECE_COLOUR,
   parameter logic [15:0] BLACK_PIECE_COLOUR = DEF_BLACK_PIECE_COLOUR
)(
   input  logic                                  clock,
   input  logic                                  resetApp,
   input  logic [CHESS_SQUARES*SQUARE_WIDTH-1:0] Layout,
   input  logic                                  FrameRequest,
   input  logic                                  PixelReady,
   output logic                                  PixelValid,
   output logic [15:0]                           PixelData,
   output logic                                  StartOfFrame,
   output logic                                  EndOfLine,
   output logic                                  EndOfFrame,
   output logic                                  Busy
);

   localparam int OFF_W = $clog2(SQUARE_PIXELS);
   localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(SQUARE_PIXELS - 1);
   localparam logic [2:0]       LAST_SQ  = 3'd7;

   renderState_t state, nextState;

   logic [CHESS_SQUARES*SQUARE_WIDTH-1:0] snapshot;
   logic [CHESS_SQUARES*SQUARE_WIDTH-1:0] board;
   logic [2:0]       sqX, sqY, nextSqX, nextSqY;
   logic [OFF_W-1:0] offX, offY, nextOffX, nextOffY;
   logic             accept, advance, load;
   logic             nextValid, nextBusy;
   logic             nextSof, nextEol, nextEof;
   logic [5:0]       sqIndex;
   logic [SQUARE_WIDTH-1:0] squareByte;
   logic [15:0]      nextPixel;

   assign accept = PixelValid & PixelReady;

   always_ff @(posedge clock) begin
      if (resetApp)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      nextValid = PixelValid;
      nextBusy  = Busy;
      nextSqX   = sqX;
      nextSqY   = sqY;
      nextOffX  = offX;
      nextOffY  = offY;
      advance   = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (FrameRequest) begin
               nextState = LOAD;
               nextBusy  = 1'b1;
            end
         end
         LOAD: begin
            nextState = STREAM;
            load      = 1'b1;
            nextValid = 1'b1;
            nextSqX   = '0;
            nextSqY   = '0;
            nextOffX  = '0;
            nextOffY  = '0;
         end
         STREAM: begin
            if (accept && EndOfFrame) begin
               nextState = IDLE;
               nextValid = 1'b0;
               nextBusy  = 1'b0;
               nextSqX   = '0;
               nextSqY   = '0;
               nextOffX  = '0;
               nextOffY  = '0;
            end else if (accept) begin
               advance = 1'b1;
               if (offX == LAST_OFF) begin
                  nextOffX = '0;
                  if (sqX == LAST_SQ) begin
                     nextSqX = '0;
                     if (offY == LAST_OFF) begin
                        nextOffY = '0;
                        nextSqY  = sqY + 3'd1;
                     end else begin
                        nextOffY = offY + 1'b1;
                     end
                  end else begin
                     nextSqX = sqX + 3'd1;
                  end
               end else begin
                  nextOffX = offX + 1'b1;
               end
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // During LOAD the snapshot is not yet written, so the first beat reads Layout directly.
   assign board      = (state == LOAD) ? Layout : snapshot;
   assign sqIndex    = {nextSqY, nextSqX};
   assign squareByte = board[sqIndex*SQUARE_WIDTH +: SQUARE_WIDTH];

   assign nextSof = (nextSqX == 3'd0) && (nextOffX == '0) && (nextSqY == 3'd0) && (nextOffY == '0);
   assign nextEol = (nextSqX == LAST_SQ) && (nextOffX == LAST_OFF);
   assign nextEof = nextEol && (nextSqY == LAST_SQ) && (nextOffY == LAST_OFF);

   chess_pixel_colour #(
      .SQUARE_PIXELS      (SQUARE_PIXELS),
      .BORDER_PIXELS      (BORDER_PIXELS),
      .PIECE_MARGIN       (PIECE_MARGIN),
      .OFF_W              (OFF_W),
      .LIGHT_COLOUR       (LIGHT_COLOUR),
      .DARK_COLOUR        (DARK_COLOUR),
      .HIGHLIGHT_COLOUR   (HIGHLIGHT_COLOUR),
      .WHITE_PIECE_COLOUR (WHITE_PIECE_COLOUR),
      .BLACK_PIECE_COLOUR (BLACK_PIECE_COLOUR)
   ) colourUnit (
      .squareByte (squareByte),
      .parityOdd  (nextSqX[0] ^ nextSqY[0]),
      .offX       (nextOffX),
      .offY       (nextOffY),
      .pixel      (nextPixel)
   );

   always_ff @(posedge clock) begin
      if (resetApp) begin
         snapshot     <= '0;
         sqX          <= '0;
         sqY          <= '0;
         offX         <= '0;
         offY         <= '0;
         PixelValid   <= 1'b0;
         PixelData    <= '0;
         StartOfFrame <= 1'b0;
         EndOfLine    <= 1'b0;
         EndOfFrame   <= 1'b0;
         Busy         <= 1'b0;
      end else begin
         sqX        <= nextSqX;
         sqY        <= nextSqY;
         offX       <= nextOffX;
         offY       <= nextOffY;
         PixelValid <= nextValid;
         Busy       <= nextBusy;
         if (load)
            snapshot <= Layout;
         if (load || advance) begin
            PixelData    <= nextPixel;
            StartOfFrame <= nextSof;
            EndOfLine    <= nextEol;
            EndOfFrame   <= nextEof;
         end else if (!nextValid) begin
            PixelData    <= '0;
            StartOfFrame <= 1'b0;
            EndOfLine    <= 1'b0;
            EndOfFrame   <= 1'b0;
         end
      end
   end

endmodule
